// File: rtl/vedic_pkg.sv
// Shared constants, sideband type and latency helper for the Vedic multiplier family.
// No logic; imported by the multiplier, its tile and anything that needs its latency.
package vedic_pkg;

    localparam int VEDIC_TILE_W = 4;
    localparam int VEDIC_MIN_W  = 4;
    localparam int VEDIC_MAX_W  = 32;

    typedef struct packed {
        logic valid;
        logic neg;
    } vedic_side_t;

    // One tile stage plus one combine stage per doubling of the operand width.
    function automatic int vedic_lat(input int width);
        return 1 + $clog2(width / VEDIC_TILE_W);
    endfunction

endpackage

// File: rtl/vedic_tile4.sv
// 4x4 Urdhva-Tiryagbhyam cell: crosswise column sums, then a weighted add; latency 0.
// Purely combinational; it has no handshake and never stalls.
module vedic_tile4
    import vedic_pkg::*;
(
    input  logic [VEDIC_TILE_W-1:0]   a_i,
    input  logic [VEDIC_TILE_W-1:0]   b_i,
    output logic [2*VEDIC_TILE_W-1:0] p_o
);

    // Column n collects every bit product a[i]&b[j] with i+j == n (at most 4 terms).
    logic [2*VEDIC_TILE_W-2:0][2:0] col;

    always_comb begin
        col = '0;
        for (int i = 0; i < VEDIC_TILE_W; i++) begin
            for (int j = 0; j < VEDIC_TILE_W; j++) begin
                col[i+j] = col[i+j] + {2'b00, a_i[i] & b_i[j]};
            end
        end
        p_o = '0;
        for (int k = 0; k < 2*VEDIC_TILE_W-1; k++) begin
            p_o = p_o + ({5'b00000, col[k]} << k);
        end
    end

endmodule

// File: rtl/vedic_mul_pipe.sv
// Pipelined signed/unsigned Vedic multiplier; latency 1 + log2(WIDTH/4), one product per cycle.
// A held output (out_valid && !out_ready) freezes every stage and drops in_ready the same cycle.
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int LAT = vedic_lat(WIDTH);
    localparam int NT  = WIDTH / VEDIC_TILE_W;
    localparam int TPW = 2 * VEDIC_TILE_W;

    if (WIDTH < VEDIC_MIN_W || WIDTH > VEDIC_MAX_W || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("vedic_mul_pipe: WIDTH must be a power of two in 4..32");
    end

    logic             adv;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_new;
    logic [TPW-1:0]   tile_p [NT*NT];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Magnitudes fit WIDTH bits even for the most negative operand.
    always_comb begin
        mag_a   = (signed_i && a[WIDTH-1]) ? -a : a;
        mag_b   = (signed_i && b[WIDTH-1]) ? -b : b;
        neg_new = signed_i & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    for (genvar i = 0; i < NT; i++) begin : g_tile_a
        for (genvar j = 0; j < NT; j++) begin : g_tile_b
            vedic_tile4 u_tile (
                .a_i (mag_a[VEDIC_TILE_W*i +: VEDIC_TILE_W]),
                .b_i (mag_b[VEDIC_TILE_W*j +: VEDIC_TILE_W]),
                .p_o (tile_p[i*NT + j])
            );
        end
    end

    // Level l holds N x N products of width PW, indexed [a_block * N + b_block].
    for (genvar l = 0; l < LAT; l++) begin : g_lvl
        localparam int N    = NT >> l;
        localparam int PW   = TPW << l;
        localparam bit LAST = (l == LAT - 1);

        logic [PW-1:0] mag    [N*N];
        logic [PW-1:0] prod_d [N*N];
        logic [PW-1:0] prod_q [N*N];
        logic          vld_in;
        logic          neg_in;

        if (l == 0) begin : g_src
            assign vld_in = in_valid;
            assign neg_in = neg_new;
            always_comb begin
                for (int t = 0; t < N*N; t++) begin
                    mag[t] = tile_p[t];
                end
            end
        end else begin : g_src
            localparam int K  = PW / 4;
            localparam int NP = 2 * N;

            logic [PW-1:0] ll, lh, hl, hh;

            assign vld_in = g_lvl[l-1].g_tag.side_q.valid;
            assign neg_in = g_lvl[l-1].g_tag.side_q.neg;

            always_comb begin
                ll = '0;
                lh = '0;
                hl = '0;
                hh = '0;
                for (int t = 0; t < N*N; t++) begin
                    mag[t] = '0;
                end
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        ll = PW'(g_lvl[l-1].prod_q[(2*i)  *NP + 2*j]);
                        lh = PW'(g_lvl[l-1].prod_q[(2*i)  *NP + 2*j + 1]);
                        hl = PW'(g_lvl[l-1].prod_q[(2*i+1)*NP + 2*j]);
                        hh = PW'(g_lvl[l-1].prod_q[(2*i+1)*NP + 2*j + 1]);
                        mag[i*N + j] = (hh << (2*K)) + ((hl + lh) << K) + ll;
                    end
                end
            end
        end

        // Sign is applied ahead of the last register so p comes straight from a flop.
        always_comb begin
            for (int t = 0; t < N*N; t++) begin
                prod_d[t] = (LAST && neg_in) ? -mag[t] : mag[t];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int t = 0; t < N*N; t++) begin
                    prod_q[t] <= '0;
                end
            end else if (adv) begin
                for (int t = 0; t < N*N; t++) begin
                    prod_q[t] <= prod_d[t];
                end
            end
        end

        if (LAST) begin : g_out
            logic vld_d, vld_q;

            always_comb begin
                vld_d = vld_in;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= vld_d;
                end
            end
        end else begin : g_tag
            vedic_side_t side_d, side_q;

            always_comb begin
                side_d       = '0;
                side_d.valid = vld_in;
                side_d.neg   = neg_in;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    side_q <= '0;
                end else if (adv) begin
                    side_q <= side_d;
                end
            end
        end
    end

    assign out_valid = g_lvl[LAT-1].g_out.vld_q;
    assign p         = g_lvl[LAT-1].prod_q[0];

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe at WIDTH 4, 8, 16 and 32 against a plain-arithmetic product model.
module tb_vedic_mul_pipe;

    logic clk;
    logic rst_n;

    logic        iv0, iv1, iv2, iv3;
    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic        or0, or1, or2, or3;
    logic        s0, s1, s2, s3;
    logic [3:0]  a0, b0;
    logic [7:0]  a1, b1;
    logic [15:0] a2, b2;
    logic [31:0] a3, b3;
    logic [7:0]  p0;
    logic [15:0] p1;
    logic [31:0] p2;
    logic [63:0] p3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat_of [4] = '{1, 2, 3, 4};
    int w_of   [4] = '{4, 8, 16, 32};

    logic        ov, ir;
    logic [63:0] pv;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] exp_a, exp_b;
    logic [63:0] exp_q [$];
    int          tin_q [$];
    int          nout;

    vedic_mul_pipe #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .signed_i(s0), .out_valid(ov0), .out_ready(or0), .p(p0));
    vedic_mul_pipe #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .signed_i(s1), .out_valid(ov1), .out_ready(or1), .p(p1));
    vedic_mul_pipe #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .signed_i(s2), .out_valid(ov2), .out_ready(or2), .p(p2));
    vedic_mul_pipe #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
        .signed_i(s3), .out_valid(ov3), .out_ready(or3), .p(p3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Product of w-bit operands, sign-extended to 64 bits when signed, kept modulo 2^(2w).
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn, input int w);
        logic [63:0] ex, ey, mask;
        ex = {32'b0, x};
        ey = {32'b0, y};
        if (sgn && x[w-1]) ex = ex - (64'd1 << w);
        if (sgn && y[w-1]) ey = ey - (64'd1 << w);
        mask = (64'd1 << (2*w)) - 64'd1;
        return (ex * ey) & mask;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic sg, input logic ordy);
        case (sel)
            0: begin iv0 = v; a0 = av[3:0];  b0 = bv[3:0];  s0 = sg; or0 = ordy; end
            1: begin iv1 = v; a1 = av[7:0];  b1 = bv[7:0];  s1 = sg; or1 = ordy; end
            2: begin iv2 = v; a2 = av[15:0]; b2 = bv[15:0]; s2 = sg; or2 = ordy; end
            default: begin iv3 = v; a3 = av; b3 = bv; s3 = sg; or3 = ordy; end
        endcase
    endtask

    task automatic sample(input int sel, output logic v, output logic [63:0] pr, output logic r);
        case (sel)
            0: begin v = ov0; pr = {56'b0, p0}; r = ir0; end
            1: begin v = ov1; pr = {48'b0, p1}; r = ir1; end
            2: begin v = ov2; pr = {32'b0, p2}; r = ir2; end
            default: begin v = ov3; pr = p3; r = ir3; end
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs == expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One isolated transaction; checks value, latency and that exactly one product emerges.
    task automatic xfer_one(input int sel, input string tag, input logic [31:0] av,
                            input logic [31:0] bv, input logic sg, input logic [63:0] expv);
        int          t_in, lat_seen, n_seen;
        logic [63:0] p_seen, prd;
        logic        v, r;
        @(negedge clk);
        drive(sel, 1'b1, av, bv, sg, 1'b1);
        t_in     = cyc;
        lat_seen = -1;
        n_seen   = 0;
        p_seen   = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(sel, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            sample(sel, v, prd, r);
            if (v) begin
                n_seen++;
                if (lat_seen < 0) begin
                    lat_seen = cyc - t_in;
                    p_seen   = prd;
                end
            end
        end
        check({tag, "_p"}, p_seen, expv);
        check_int({tag, "_lat"}, lat_seen, lat_of[sel]);
        check_int({tag, "_count"}, n_seen, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        for (int s = 0; s < 4; s++) begin
            sample(s, ov, pv, ir);
            check_bit("rst_out_valid", ov, 1'b0);
            check("rst_p", pv, 64'd0);
            check_bit("rst_in_ready", ir, 1'b1);
        end
        rst_n = 1'b1;
        #1;
        sample(1, ov, pv, ir);
        check_bit("post_rst_in_ready", ir, 1'b1);

        xfer_one(1, "w8_u_ff_ff",   32'hFF, 32'hFF, 1'b0, 64'hFE01);
        xfer_one(1, "w8_s_80_80",   32'h80, 32'h80, 1'b1, 64'h4000);
        xfer_one(1, "w8_s_80_7f",   32'h80, 32'h7F, 1'b1, 64'hC080);
        xfer_one(1, "w8_s_ff_01",   32'hFF, 32'h01, 1'b1, 64'hFFFF);
        xfer_one(0, "w4_u_f_f",     32'hF,  32'hF,  1'b0, 64'hE1);
        xfer_one(0, "w4_s_8_8",     32'h8,  32'h8,  1'b1, 64'h40);
        xfer_one(3, "w32_s_min",    32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        xfer_one(3, "w32_u_max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);

        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                ra = $urandom & wmask(w_of[s]);
                rb = $urandom & wmask(w_of[s]);
                rs = 1'($urandom_range(0, 1));
                xfer_one(s, "rand", ra, rb, rs, ref_mul(ra, rb, rs, w_of[s]));
            end
        end

        // WIDTH=16 back-to-back stream with mixed signedness.
        nout = 0;
        for (int k = 0; k < 1010; k++) begin
            @(negedge clk);
            sample(2, ov, pv, ir);
            if (ov) begin
                if (exp_q.size() == 0) begin
                    check_bit("stream_stale", ov, 1'b0);
                end else begin
                    check("stream_p", pv, exp_q.pop_front());
                    check_int("stream_lat", cyc - tin_q.pop_front(), 3);
                    nout++;
                end
            end
            if (k < 1000) begin
                check_bit("stream_in_ready", ir, 1'b1);
                ra = $urandom & 32'hFFFF;
                rb = $urandom & 32'hFFFF;
                rs = 1'($urandom_range(0, 1));
                drive(2, 1'b1, ra, rb, rs, 1'b1);
                exp_q.push_back(ref_mul(ra, rb, rs, 16));
                tin_q.push_back(cyc);
            end else begin
                drive(2, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
            end
        end
        check_int("stream_count", nout, 1000);

        // WIDTH=8 backpressure: two products in flight, output held for five cycles.
        ra = $urandom & 32'hFF; rb = $urandom & 32'hFF; rs = 1'($urandom_range(0, 1));
        exp_a = ref_mul(ra, rb, rs, 8);
        @(negedge clk);
        drive(1, 1'b1, ra, rb, rs, 1'b0);
        ra = $urandom & 32'hFF; rb = $urandom & 32'hFF; rs = 1'($urandom_range(0, 1));
        exp_b = ref_mul(ra, rb, rs, 8);
        @(negedge clk);
        sample(1, ov, pv, ir);
        check_bit("bp_in_ready_before", ir, 1'b1);
        drive(1, 1'b1, ra, rb, rs, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            sample(1, ov, pv, ir);
            check_bit("bp_out_valid", ov, 1'b1);
            check("bp_p_hold", pv, exp_a);
            check_bit("bp_in_ready", ir, 1'b0);
        end
        drive(1, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
        @(negedge clk);
        sample(1, ov, pv, ir);
        check_bit("bp_second_valid", ov, 1'b1);
        check("bp_second_p", pv, exp_b);
        @(negedge clk);
        sample(1, ov, pv, ir);
        check_bit("bp_drained", ov, 1'b0);

        // WIDTH=32 reset with four products in flight.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(3, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
        @(negedge clk);
        drive(3, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
        sample(3, ov, pv, ir);
        check_bit("mid_rst_inflight", ov, 1'b1);
        rst_n = 1'b0;
        #1;
        sample(3, ov, pv, ir);
        check_bit("mid_rst_out_valid", ov, 1'b0);
        check("mid_rst_p", pv, 64'd0);
        check_bit("mid_rst_in_ready", ir, 1'b1);
        repeat (2) @(negedge clk);
        sample(3, ov, pv, ir);
        check_bit("mid_rst_hold_valid", ov, 1'b0);
        rst_n = 1'b1;
        ra = $urandom; rb = $urandom; rs = 1'b1;
        xfer_one(3, "after_rst", ra, rb, rs, ref_mul(ra, rb, rs, 32));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vedic_mul_pipe.md
# vedic_mul_pipe

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. It generalises the 4x4 combinational Vedic cell to any power-of-two operand width by recursive quadrant decomposition. It adds per-transaction signed/unsigned mode, one register stage per recursion level, and valid/ready handshakes on both sides. It sits in the datapath library as the drop-in multiplier for DSP and MAC blocks that need a throughput of one product per cycle at higher clock rates.

## Interface
- WIDTH, default 8: operand width. Must be a power of two, 4..32; any other value is an elaboration error.
- LAT, derived (not overridable): 1 + log2(WIDTH/4), the pipeline latency in cycles. This gives 1, 2, 3 and 4 for WIDTH 4, 8, 16 and 32.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; synchronous deassertion is handled upstream.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_i  in  1  1 = treat a and b as two's complement; 0 = unsigned.
- out_valid  out  1  product is valid.
- out_ready  in  1  downstream accepts the product.
- p  out  2*WIDTH  product: two's complement when the captured signed_i was 1, unsigned otherwise.

## Operation
- Transfer rule:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - When adv = 0, every pipeline register holds, including valid bits and sign tags.
- Stage 1 (capture):
  - In signed mode, each operand becomes its magnitude. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned in WIDTH bits.
  - The result sign is neg = signed_i & (a[MSB] ^ b[MSB]).
  - The magnitudes are split into (WIDTH/4)^2 4x4 tiles. Each tile product is computed combinationally (8 bits) and registered, together with neg and the stage valid bit.
- Stages 2..LAT (combine):
  - Each level merges groups of four quadrant products of width 2k into one product of width 4k: P = HH<<2k + (HL+LH)<<k + LL, where k is the quadrant operand width.
  - The result is registered. neg and valid propagate alongside.
- Final stage: when neg = 1, the registered value is the two's-complement negation of the magnitude product, applied before the last register. p is therefore a pure register output.
- Unsigned mode ignores the operand MSB semantics entirely; the arithmetic is modular on 2*WIDTH bits. Overflow is impossible.
- Bubbles are not collapsed. An invalid slot travels through the pipeline like data, with its valid bit 0.

## Timing
- Latency: an input transferred in cycle t appears with out_valid = 1 in cycle t+LAT, provided adv stayed 1 throughout.
- Throughput: one product per cycle while out_ready = 1.
- Backpressure:
  - out_valid && !out_ready freezes all stages and drops in_ready in the same cycle.
  - p and out_valid hold stable until the transfer happens.
- Simultaneous input and output transfer in one cycle is legal and is the steady state.
- Reset: all valid bits, neg tags, tile and partial registers, and p clear to 0, and out_valid = 0.
  - in_ready = 1 during reset and right after it.
  - Assertion mid-operation discards all in-flight products immediately; no partial output is emitted.
- signed_i is sampled only on an input transfer. Changing it between transactions never affects products already in flight.

## Structure
- Shared package vedic_pkg holds:
  - VEDIC_TILE_W = 4 and the supported widths 4..32;
  - function vedic_lat(width) returning 1 + log2(width/4), used by the block and by benches;
  - a typedef for the per-stage sideband {valid, neg}.
- Sub-module: vedic_tile4, a combinational 4x4 Vedic tile (8-bit product) instantiated (WIDTH/4)^2 times in stage 1.
- Combine levels are built with generate loops, with no further sub-modules.

## Test plan
- WIDTH=8, unsigned: a=255, b=255, out_ready=1 -> p=0xFE01 exactly 2 cycles after the transfer.
- WIDTH=8, signed: a=0x80, b=0x80 -> p=0x4000. a=0x80, b=0x7F -> p=0xC080. a=0xFF, b=0x01 -> p=0xFFFF.
- WIDTH=16: back-to-back stream of 1000 random signed/unsigned pairs with out_ready=1 -> one product per cycle, all matching the reference model, latency 3.
- Backpressure at WIDTH=8: hold out_ready=0 for 5 cycles with 2 products in flight -> in_ready=0, p stable, no loss or duplication; order is preserved after release.
- Reset mid-stream at WIDTH=32: assert rst_n=0 with 4 products in flight -> out_valid=0 and p=0 immediately. After release, the first new input appears after exactly 4 cycles with no stale outputs.
- WIDTH=4: a=0xF, b=0xF, unsigned -> p=0xE1 at latency 1. Signed a=0x8, b=0x8 -> p=0x40.
